alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Issue and writeback controller that sits directly in front of the combinational 8-bit ALU (ops ADD/SUB/MUL/DIV on 2-bit op).
- Holds an operand register file and accepts one instruction per handshake.
- Drives the ALU's a/b/op inputs from registers, then writes the ALU result f back into the destination register.
- Flags divide-by-zero and suppresses that writeback.

Parameters:
- WIDTH, 8, datapath width; matches the ALU operand and result width.
- AW, 3, register-file address width; gives 2**AW registers.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  unit can accept an instruction.
- in_instr  input  2+3*AW  fields {op[1:0], rd, rs1, rs2}, MSB first.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_op  output  2  to ALU op: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- alu_f  input  WIDTH  from ALU f; combinational result.
- done  output  1  one-cycle pulse when an instruction retires.
- result  output  WIDTH  alu_f captured at retirement; held until next retirement.
- div0  output  1  set with done when the retired op was DIV with b==0; held like result.
- ld_en  input  1  register preload write enable.
- ld_addr  input  AW  preload address.
- ld_data  input  WIDTH  preload data.
- rd_addr  input  AW  observation read address.
- rd_data  output  WIDTH  combinational read of rf[rd_addr].

Behaviour:
- Reset (rst_n low, asynchronous):
  - All rf entries = 0.
  - alu_a = alu_b = 0, alu_op = 00.
  - done = 0, result = 0, div0 = 0.
  - State = IDLE.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready at a rising edge, register alu_a <= rf[rs1], alu_b <= rf[rs2], alu_op <= op, and latch rd.
    - Next state = EXEC.
  - EXEC:
    - in_ready = 0; in_valid is ignored.
    - alu_a, alu_b and alu_op are stable for the whole cycle.
    - At the rising edge ending EXEC: result <= alu_f, done <= 1, div0 <= (alu_op==11 && alu_b==0).
    - At the same edge, if not div0, write rf[rd] <= alu_f.
    - Next state = IDLE.
- Latency and throughput:
  - Accept at edge N; retire at edge N+1; done is high during cycle N+1→N+2.
  - Throughput is one instruction per 2 cycles.
- done is high for exactly one cycle per retirement and never otherwise.
- Arithmetic is performed entirely by the ALU. The unit stores alu_f unmodified (WIDTH bits, wrap and truncation as the ALU produces).
- Divide-by-zero: rf[rd] is unchanged; result still captures alu_f as driven.
- Back-to-back dependency: the writeback completes before the next accept is possible, so a following instruction reading rd sees the new value. No bypass is required.
- Preload:
  - ld_en writes rf[ld_addr] <= ld_data at the rising edge, in any state.
  - If the same edge performs an EXEC writeback to the same address, the writeback wins.
  - If ld_en writes a source register in the same edge as an IDLE accept, the accept reads the old value.
- rs1 == rs2 and rd == rs1/rs2 are legal; reads use pre-edge values.
- Reset asserted during EXEC: the instruction is dropped, there is no done pulse, and rf is cleared.
- in_instr is sampled only on the accept edge.

Test Plan:
- Reset: preload r1=15, r2=10, then pulse rst_n low mid-EXEC of ADD r3=r1+r2 → done never pulses; rd_data for all addresses = 0; alu_a/alu_b/alu_op = 0.
- ADD/SUB:
  - Preload r1=15, r2=10; issue ADD r3,r1,r2 → alu_a=15, alu_b=10 in EXEC; done one cycle later; result=25; r3=25.
  - Then preload r4=25, r5=5; issue SUB r6,r4,r5 → result=20, r6=20.
- MUL and wrap: r1=3, r2=4, MUL r7,r1,r2 → r7=12. Then r1=200, r2=100, ADD r0,r1,r2 → r0=44 (300 mod 256).
- DIV and div-by-zero:
  - r1=20, r2=4, preload r3=99; DIV r3,r1,r2 → r3=5, div0=0.
  - Then r2=0; DIV r3,r1,r2 → div0=1, done=1, r3 stays 5.
- Handshake and dependency:
  - Hold in_valid high with ADD r1,r1,r1 (r1=1) for 6 cycles → accepts only in IDLE cycles; in_ready alternates 1,0.
  - Exactly 3 done pulses; r1 = 2, 4, 8.
- Preload collision: ld_en to r3 with ld_data=77 on the same edge as the EXEC writeback of ADD r3 (result 25) → r3=25.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// -----------------------------------------------------------------------------
// alu_issue_unit_if
//   Instruction handshake and retirement bus of the ALU issue unit.
//
//   in_valid  master -> slave  instruction present
//   in_ready  slave  -> master unit can accept an instruction
//   in_instr  master -> slave  {op[1:0], rd, rs1, rs2}, MSB first
//   done      slave  -> master one-cycle pulse per retired instruction
//   result    slave  -> master ALU result captured at retirement
//   div0      slave  -> master retired op was DIV with a zero divisor
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface alu_issue_unit_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [2+3*AW-1:0] in_instr;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              div0;

  // Issuer side (the bench or an upstream sequencer).
  modport master (
    output in_valid,
    output in_instr,
    input  in_ready,
    input  done,
    input  result,
    input  div0
  );

  // Issue unit side.
  modport slave (
    input  in_valid,
    input  in_instr,
    output in_ready,
    output done,
    output result,
    output div0
  );
endinterface

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//   Issue/writeback controller in front of a combinational WIDTH-bit ALU.
//   Holds a 2**AW entry register file, accepts one instruction per handshake,
//   drives the ALU operands from registers for one EXEC cycle, then writes the
//   ALU result back to the destination register. A DIV with a zero divisor is
//   flagged on div0 and its writeback is suppressed.
//
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     bus      alu_issue_unit_if.slave: in_valid/in_ready/in_instr handshake,
//              done/result/div0 retirement outputs
//     alu_a    ALU operand a (registered)
//     alu_b    ALU operand b (registered)
//     alu_op   ALU opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV (registered)
//     alu_f    ALU combinational result
//     ld_en    register preload write enable
//     ld_addr  preload address
//     ld_data  preload data
//     rd_addr  observation read address
//     rd_data  combinational read of rf[rd_addr]
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_issue_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_unit_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int NREG = 1 << AW;
  localparam int IW   = 2 + 3 * AW;

  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [WIDTH-1:0] alu_a_q,  alu_a_d;
  logic [WIDTH-1:0] alu_b_q,  alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [AW-1:0]    rd_q,     rd_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             div0_q,   div0_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];

  logic             in_ready;
  logic             wb_en;
  logic             div_by_zero;
  logic [NREG-1:0]  wb_hit;
  logic [NREG-1:0]  ld_hit;

  // ---------------------------------------------------------------------------
  // Instruction field decode: {op, rd, rs1, rs2}, MSB first
  // ---------------------------------------------------------------------------
  logic [1:0]    op_f;
  logic [AW-1:0] rd_f;
  logic [AW-1:0] rs1_f;
  logic [AW-1:0] rs2_f;

  assign op_f  = bus.in_instr[IW-1 -: 2];
  assign rd_f  = bus.in_instr[3*AW-1 -: AW];
  assign rs1_f = bus.in_instr[2*AW-1 -: AW];
  assign rs2_f = bus.in_instr[AW-1:0];

  // Divide-by-zero is judged on the operands actually presented to the ALU.
  assign div_by_zero = (alu_op_q == OP_DIV) && (alu_b_q == '0);

  // ---------------------------------------------------------------------------
  // Control FSM: next state and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    result_d = result_q;
    div0_d   = div0_q;
    in_ready = 1'b0;
    wb_en    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          // Reads use the pre-edge register contents, so a same-edge preload
          // of a source register is not seen by this instruction.
          alu_a_d  = rf_q[rs1_f];
          alu_b_d  = rf_q[rs2_f];
          alu_op_d = op_f;
          rd_d     = rd_f;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        // Operands have been stable all cycle; alu_f is settled by this edge.
        result_d = alu_f;
        done_d   = 1'b1;
        div0_d   = div_by_zero;
        wb_en    = !div_by_zero;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file next values. Writeback has priority over a same-address
  // preload on the same edge.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      assign wb_hit[gi] = wb_en && (rd_q == AW'(gi));
      assign ld_hit[gi] = ld_en && (ld_addr == AW'(gi));
      assign rf_d[gi]   = wb_hit[gi] ? alu_f
                        : ld_hit[gi] ? ld_data
                        : rf_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Flops. Reset mid-EXEC simply drops the instruction: done_q clears and the
  // FSM returns to IDLE, so no retirement pulse is ever produced for it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      div0_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      result_q <= result_d;
      div0_q   <= div0_d;
      rf_q     <= rf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready = in_ready;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.div0     = div0_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rd_data      = rf_q[rd_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
`timescale 1ns/1ps

module tb_alu_issue_unit;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int NREG  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] alu_a, alu_b, alu_f;
  logic [1:0]       alu_op;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  alu_issue_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_issue_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_f   (alu_f),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: plain arithmetic, truncated to 8 bits; DIV by 0 gives FF.
  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a) * int'(b);
      default: r = (b == 0) ? 255 : int'(a) / int'(b);
    endcase
    return r[7:0];
  endfunction

  always_comb alu_f = alu_ref(alu_op, alu_a, alu_b);

  // Scoreboard
  typedef struct {
    logic [7:0] res;
    logic       dz;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_rf [NREG];
  int         total    = 0;
  int         bad      = 0;
  int         done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding instruction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, bus.done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("retire result=%0d div0=%0d (want %0d/%0d)", bus.result, bus.div0, e.res, e.dz);
        chk("result", {24'd0, bus.result}, {24'd0, e.res});
        chk("div0", {31'd0, bus.div0}, {31'd0, e.dz});
      end
    end
  end

  task automatic expect_reg(input int addr, input logic [7:0] val);
    rd_addr = addr[2:0];
    #1;
    chk($sformatf("rf[%0d]", addr), {24'd0, rd_data}, {24'd0, val});
  endtask

  task automatic preload(input int addr, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_addr = addr[2:0];
    ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    model_rf[addr] = data;
    $display("preload r%0d=%0d", addr, data);
  endtask

  // One full instruction: accept edge, EXEC cycle, retire edge.
  // Optional preloads on the accept edge (la_*) and the retire edge (le_*).
  task automatic issue(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                       input bit la_en, input int la_addr, input logic [7:0] la_data,
                       input bit le_en, input int le_addr, input logic [7:0] le_data,
                       input bit junk);
    logic [7:0] a, b, f;
    logic       dz;
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    a  = model_rf[rs1];
    b  = model_rf[rs2];
    f  = alu_ref(op, a, b);
    dz = (op == 2'd3) && (b == 8'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = {op, rd[2:0], rs1[2:0], rs2[2:0]};
    ld_en   = la_en;
    ld_addr = la_addr[2:0];
    ld_data = la_data;
    @(posedge clk); #1;
    exp_q.push_back('{res: f, dz: dz});
    // During EXEC the request line is ignored; throw junk at it.
    bus.in_valid = junk;
    bus.in_instr = 11'($urandom);
    ld_en   = le_en;
    ld_addr = le_addr[2:0];
    ld_data = le_data;
    chk("in_ready_exec", {31'd0, bus.in_ready}, 32'd0);
    chk("alu_a", {24'd0, alu_a}, {24'd0, a});
    chk("alu_b", {24'd0, alu_b}, {24'd0, b});
    chk("alu_op", {30'd0, alu_op}, {30'd0, op});
    chk("done_in_exec", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ld_en = 1'b0;
    if (la_en) model_rf[la_addr] = la_data;
    if (le_en) model_rf[le_addr] = le_data;
    if (!dz)   model_rf[rd] = f;
    $display("issue op=%0d rd=%0d rs1=%0d rs2=%0d a=%0d b=%0d f=%0d div0=%0d", op, rd, rs1, rs2, a, b, f, dz);
    expect_reg(rd, model_rf[rd]);
  endtask

  task automatic issue_plain(input logic [1:0] op, input int rd, input int rs1, input int rs2);
    issue(op, rd, rs1, rs2, 1'b0, 0, 8'd0, 1'b0, 0, 8'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    logic [7:0] tmp;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    rd_addr      = '0;
    for (int i = 0; i < NREG; i++) model_rf[i] = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    chk("rst_div0", {31'd0, bus.div0}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset mid-EXEC drops the instruction and clears the register file.
    preload(1, 8'd15);
    preload(2, 8'd10);
    cnt0 = done_cnt;
    bus.in_valid = 1'b1;
    bus.in_instr = {2'd0, 3'd3, 3'd1, 3'd2};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) model_rf[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt, cnt0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
    chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
    for (int i = 0; i < NREG; i++) expect_reg(i, 8'd0);

    // ADD / SUB
    preload(1, 8'd15);
    preload(2, 8'd10);
    issue_plain(2'd0, 3, 1, 2);
    expect_reg(3, 8'd25);
    preload(4, 8'd25);
    preload(5, 8'd5);
    issue_plain(2'd1, 6, 4, 5);
    expect_reg(6, 8'd20);

    // MUL and wrap
    preload(1, 8'd3);
    preload(2, 8'd4);
    issue_plain(2'd2, 7, 1, 2);
    expect_reg(7, 8'd12);
    preload(1, 8'd200);
    preload(2, 8'd100);
    issue_plain(2'd0, 0, 1, 2);
    expect_reg(0, 8'd44);

    // DIV and divide-by-zero
    preload(1, 8'd20);
    preload(2, 8'd4);
    preload(3, 8'd99);
    issue_plain(2'd3, 3, 1, 2);
    expect_reg(3, 8'd5);
    preload(2, 8'd0);
    issue_plain(2'd3, 3, 1, 2);
    expect_reg(3, 8'd5);

    // Handshake: in_valid held high for 6 cycles with ADD r1,r1,r1.
    preload(1, 8'd1);
    cnt0 = done_cnt;
    bus.in_valid = 1'b1;
    bus.in_instr = {2'd0, 3'd1, 3'd1, 3'd1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ready_alt", {31'd0, bus.in_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 0) begin
        tmp = model_rf[1] + model_rf[1];
        exp_q.push_back('{res: tmp, dz: 1'b0});
        model_rf[1] = tmp;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("held_valid_dones", done_cnt - cnt0, 32'd3);
    expect_reg(1, 8'd8);

    // Preload collisions: writeback beats same-edge preload; accept reads old value.
    preload(1, 8'd15);
    preload(2, 8'd10);
    issue(2'd0, 3, 1, 2, 1'b0, 0, 8'd0, 1'b1, 3, 8'd77, 1'b0);
    expect_reg(3, 8'd25);
    issue(2'd0, 4, 1, 2, 1'b1, 1, 8'd50, 1'b0, 0, 8'd0, 1'b0);
    expect_reg(4, 8'd25);
    expect_reg(1, 8'd50);

    // Randomized traffic against the reference register file.
    for (int i = 0; i < NREG; i++) preload(i, 8'($urandom));
    for (int n = 0; n < 40; n++) begin
      int rd, rs1, rs2;
      logic [1:0] op;
      op  = 2'($urandom_range(0, 3));
      rd  = $urandom_range(0, NREG - 1);
      rs1 = $urandom_range(0, NREG - 1);
      rs2 = $urandom_range(0, NREG - 1);
      if ($urandom_range(0, 4) == 0) preload(rs2, 8'd0);
      issue(op, rd, rs1, rs2,
            $urandom_range(0, 3) == 0, $urandom_range(0, NREG - 1), 8'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, NREG - 1), 8'($urandom),
            1'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NREG; i++) expect_reg(i, model_rf[i]);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
